register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  Parametrised multi-entry register file for the RV32I core, replacing discrete per-register
//  instances: one write port, two synchronous read ports (rs1/rs2), x0 hardwired to zero,
//  optional write-to-read bypass, and a self-clearing sequencer after reset.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DataWidth  32  bits per register
//  AddrWidth  5   address bits; NumRegs = 2**AddrWidth
//  Bypass     1   1: same-cycle write to a read address returns new data; 0: returns old data
// PORTS
//  Clk     in   1          clock; all state updates on rising edge
//  Reset   in   1          synchronous, active-high
//  We      in   1          write enable
//  WAddr   in   AddrWidth  write address
//  WData   in   DataWidth  write data
//  RdEnA   in   1          read enable, port A
//  RAddrA  in   AddrWidth  read address, port A
//  RDataA  out  DataWidth  read data, port A (registered)
//  RdEnB   in   1          read enable, port B
//  RAddrB  in   AddrWidth  read address, port B
//  RDataB  out  DataWidth  read data, port B (registered)
//  Ready   out  1          1 = clear complete, accesses honoured
// BEHAVIOUR
//  - Reset (sampled high at edge): state <= CLEAR, ClrIdx <= 1, RDataA/RDataB <= 0, Ready <= 0.
//    Array contents are not touched by Reset itself; the sequencer clears them.
//  - FSM states CLEAR, RUN.
//    CLEAR: each cycle mem[ClrIdx] <= 0, ClrIdx++. When ClrIdx == NumRegs-1 is cleared -> RUN.
//           Clear takes NumRegs-1 cycles after Reset drops; Ready rises on the following edge.
//           We ignored; reads return 0 (RData <= 0 when RdEn high).
//    RUN:   normal operation, Ready = 1. No exit except Reset.
//  - Reset during CLEAR or RUN: restart CLEAR at ClrIdx = 1; in-flight write that cycle dropped.
//  - Write (RUN): We && WAddr != 0 -> mem[WAddr] <= WData at edge. WAddr == 0 dropped silently.
//  - Read (RUN): RdEnX high -> RDataX <= value at edge; valid one cycle after request.
//    RdEnX low -> RDataX holds previous value.
//  - RAddrX == 0 -> RDataX <= 0 regardless of array or bypass.
//  - Same-cycle We with WAddr == RAddrX != 0: Bypass=1 -> RDataX <= WData;
//    Bypass=0 -> RDataX <= old mem[RAddrX]. Write commits in both cases.
//  - Both ports same address: both return identical data, including bypass.
//  - ClrIdx width AddrWidth; no wrap (FSM leaves CLEAR at NumRegs-1).
// STRUCTURE
//  - Shared package rf_pkg: state encoding (RF_CLEAR, RF_RUN), default DataWidth/AddrWidth.
//  - One sub-module, rf_read_port (address-0 mask, bypass mux, output register, hold),
//    instantiated twice. Top holds array, write logic and clear FSM.
// TESTING
//  1. Reset 2 cycles then release, AddrWidth=5 -> Ready low 31 cycles, high on 32nd edge;
//     read all 32 -> 0.
//  2. Write x5 = 0xDEADBEEF, then RdEnA at x5 -> RDataA = 0xDEADBEEF one cycle later;
//     RdEnA low -> held.
//  3. Write x0 = 0xFFFFFFFF, read x0 on A and B -> both 0x00000000.
//  4. x7 = 0x11111111; same cycle write x7 = 0x22222222 with read x7 on A and B
//     -> 0x22222222 (Bypass=1), 0x11111111 (Bypass=0); next read -> 0x22222222.
//  5. Fill x1..x31 = index; assert Reset in RUN for 1 cycle -> Ready low, RData = 0,
//     re-clear; after Ready all reads 0.
//  6. Write during CLEAR (x3 = 0xABCD) -> ignored; x3 reads 0 after Ready.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the RV32I register file: sequencer state encoding
// and default geometry.
package rf_pkg;

   localparam int unsigned RF_DATA_WIDTH = 32;
   localparam int unsigned RF_ADDR_WIDTH = 5;

   // Sequencer states: CLEAR zeroes the array after reset, RUN is normal use.
   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// One synchronous read port of the register file.
// Applies the address-0 mask, the optional write-to-read bypass and holds the
// registered output while RdEn is low.
// Ports:
//   Clk, Reset      clock and synchronous active-high reset
//   RdEn, RAddr     read request for this port
//   Run             array is cleared and accesses are honoured
//   WrEn            a write commits this cycle (already qualified by top)
//   WAddr, WData    the committing write, used for bypass
//   MemData         current array contents at RAddr
//   RData           registered read data
module rf_read_port
   import rf_pkg::*;
#(
   parameter int unsigned DataWidth = RF_DATA_WIDTH,
   parameter int unsigned AddrWidth = RF_ADDR_WIDTH,
   parameter bit          Bypass    = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 RdEn,
   input  logic [AddrWidth-1:0] RAddr,
   input  logic                 Run,
   input  logic                 WrEn,
   input  logic [AddrWidth-1:0] WAddr,
   input  logic [DataWidth-1:0] WData,
   input  logic [DataWidth-1:0] MemData,
   output logic [DataWidth-1:0] RData
);

   logic                 bypass_hit_c;
   logic [DataWidth-1:0] rdata_next_c;

   // Select the value captured on a read request.
   always_comb begin
      bypass_hit_c = Bypass && WrEn && (WAddr == RAddr);
      rdata_next_c = MemData;
      if (!Run || (RAddr == '0)) begin
         rdata_next_c = '0;
      end else if (bypass_hit_c) begin
         rdata_next_c = WData;
      end
   end

   // Output register; holds when no read is requested.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         RData <= '0;
      end else if (RdEn) begin
         RData <= rdata_next_c;
      end
   end

endmodule : rf_read_port

// File: rtl/register_file.sv
// Multi-entry register file for the RV32I core: one write port, two
// registered read ports, x0 hardwired to zero and a post-reset sequencer that
// zeroes x1..x(NumRegs-1) before accesses are honoured.
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   We, WAddr, WData  write port (from writeback)
//   RdEnA, RAddrA     read request port A (rs1)
//   RDataA            registered read data port A
//   RdEnB, RAddrB     read request port B (rs2)
//   RDataB            registered read data port B
//   Ready             clear complete, accesses honoured
module register_file
   import rf_pkg::*;
#(
   parameter int unsigned DataWidth = RF_DATA_WIDTH,
   parameter int unsigned AddrWidth = RF_ADDR_WIDTH,
   parameter bit          Bypass    = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 We,
   input  logic [AddrWidth-1:0] WAddr,
   input  logic [DataWidth-1:0] WData,
   input  logic                 RdEnA,
   input  logic [AddrWidth-1:0] RAddrA,
   output logic [DataWidth-1:0] RDataA,
   input  logic                 RdEnB,
   input  logic [AddrWidth-1:0] RAddrB,
   output logic [DataWidth-1:0] RDataB,
   output logic                 Ready
);

   localparam int unsigned NumRegs = 2 ** AddrWidth;
   localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumRegs - 1);

   rf_state_e            state;
   rf_state_e            state_next;
   logic [AddrWidth-1:0] clr_idx;
   logic                 clr_we_c;
   logic                 wr_fire_c;
   logic [DataWidth-1:0] mem [NumRegs];

   // Sequencer next state: CLEAR walks the array once, then RUN until reset.
   always_comb begin
      state_next = state;
      clr_we_c   = 1'b0;
      case (state)
         RF_CLEAR: begin
            clr_we_c = 1'b1;
            if (clr_idx == LastIdx) begin
               state_next = RF_RUN;
            end
         end
         RF_RUN: begin
            state_next = RF_RUN;
         end
         default: begin
            state_next = RF_CLEAR;
         end
      endcase
   end

   // Sequencer registers; Ready trails entry to RUN by one edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= RF_CLEAR;
         clr_idx <= AddrWidth'(1);
         Ready   <= 1'b0;
      end else begin
         state <= state_next;
         Ready <= (state == RF_RUN);
         if (clr_we_c && (clr_idx != LastIdx)) begin
            clr_idx <= clr_idx + AddrWidth'(1);
         end
      end
   end

   // Architectural write: only once cleared, never to x0, dropped under reset.
   assign wr_fire_c = We && Ready && !Reset && (WAddr != '0);

   // Storage array; x0 is never written and is masked on read.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (clr_we_c) begin
            mem[clr_idx] <= '0;
         end else if (wr_fire_c) begin
            mem[WAddr] <= WData;
         end
      end
   end

   rf_read_port #(
      .DataWidth (DataWidth),
      .AddrWidth (AddrWidth),
      .Bypass    (Bypass)
   ) u_port_a (
      .Clk     (Clk),
      .Reset   (Reset),
      .RdEn    (RdEnA),
      .RAddr   (RAddrA),
      .Run     (Ready),
      .WrEn    (wr_fire_c),
      .WAddr   (WAddr),
      .WData   (WData),
      .MemData (mem[RAddrA]),
      .RData   (RDataA)
   );

   rf_read_port #(
      .DataWidth (DataWidth),
      .AddrWidth (AddrWidth),
      .Bypass    (Bypass)
   ) u_port_b (
      .Clk     (Clk),
      .Reset   (Reset),
      .RdEn    (RdEnB),
      .RAddr   (RAddrB),
      .Run     (Ready),
      .WrEn    (wr_fire_c),
      .WAddr   (WAddr),
      .WData   (WData),
      .MemData (mem[RAddrB]),
      .RData   (RDataB)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance with bypass, one without,
// sharing all inputs.
module tb_register_file;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        We;
   logic [4:0]  WAddr;
   logic [31:0] WData;
   logic        RdEnA;
   logic [4:0]  RAddrA;
   logic        RdEnB;
   logic [4:0]  RAddrB;
   logic [31:0] RDataA, RDataB, RDataA_nb, RDataB_nb;
   logic        Ready, Ready_nb;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   register_file #(.DataWidth(32), .AddrWidth(5), .Bypass(1'b1)) dut (
      .Clk(Clk), .Reset(Reset), .We(We), .WAddr(WAddr), .WData(WData),
      .RdEnA(RdEnA), .RAddrA(RAddrA), .RDataA(RDataA),
      .RdEnB(RdEnB), .RAddrB(RAddrB), .RDataB(RDataB), .Ready(Ready)
   );

   register_file #(.DataWidth(32), .AddrWidth(5), .Bypass(1'b0)) dut_nb (
      .Clk(Clk), .Reset(Reset), .We(We), .WAddr(WAddr), .WData(WData),
      .RdEnA(RdEnA), .RAddrA(RAddrA), .RDataA(RDataA_nb),
      .RdEnB(RdEnB), .RAddrB(RAddrB), .RDataB(RDataB_nb), .Ready(Ready_nb)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      We = 1'b0; WAddr = '0; WData = '0;
      RdEnA = 1'b0; RAddrA = '0; RdEnB = 1'b0; RAddrB = '0;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      We = 1'b1; WAddr = a; WData = d;
      tick();
      We = 1'b0;
   endtask

   // Read every register on both ports of both instances, expecting zero.
   task automatic read_all_zero(input string tag);
      int bad = 0;
      for (int r = 0; r < 32; r++) begin
         RdEnA = 1'b1; RAddrA = 5'(r);
         RdEnB = 1'b1; RAddrB = 5'(31 - r);
         tick();
         if ((RDataA | RDataB | RDataA_nb | RDataB_nb) !== 32'h0) bad++;
      end
      RdEnA = 1'b0; RdEnB = 1'b0;
      check(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      int hi_cnt;
      int wait_cnt;
      int bad;

      idle();
      Reset = 1'b1;

      // 1. Reset, clear sequence timing, all zero afterwards
      tick(); tick();
      check("reset_ready", 32'(Ready), 32'd0);
      check("reset_rdata_a", RDataA, 32'h0);
      check("reset_rdata_b", RDataB, 32'h0);
      Reset = 1'b0;
      hi_cnt = 0;
      for (int i = 0; i < 31; i++) begin
         tick();
         if (Ready || Ready_nb) hi_cnt++;
      end
      check("clear_ready_low_31", 32'(hi_cnt), 32'd0);
      tick();
      check("ready_edge_32", 32'(Ready), 32'd1);
      check("ready_edge_32_nb", 32'(Ready_nb), 32'd1);
      read_all_zero("post_reset_zero");

      // 2. Write then read, then hold with RdEn low
      write(5'd5, 32'hDEADBEEF);
      RdEnA = 1'b1; RAddrA = 5'd5;
      tick();
      check("rd_x5", RDataA, 32'hDEADBEEF);
      check("rd_x5_nb", RDataA_nb, 32'hDEADBEEF);
      RdEnA = 1'b0; RAddrA = 5'd6;
      tick(); tick();
      check("hold_x5", RDataA, 32'hDEADBEEF);

      // 3. x0 hardwired to zero, even with a same-cycle write to it
      We = 1'b1; WAddr = 5'd0; WData = 32'hFFFFFFFF;
      RdEnA = 1'b1; RAddrA = 5'd0; RdEnB = 1'b1; RAddrB = 5'd0;
      tick();
      We = 1'b0;
      check("x0_bypass_a", RDataA, 32'h0);
      check("x0_bypass_b", RDataB, 32'h0);
      tick();
      check("x0_read_a", RDataA, 32'h0);
      check("x0_read_b_nb", RDataB_nb, 32'h0);
      RdEnA = 1'b0; RdEnB = 1'b0;

      // 4. Same-cycle write/read: bypass vs old data, write commits in both
      write(5'd7, 32'h11111111);
      We = 1'b1; WAddr = 5'd7; WData = 32'h22222222;
      RdEnA = 1'b1; RAddrA = 5'd7; RdEnB = 1'b1; RAddrB = 5'd7;
      tick();
      We = 1'b0;
      check("byp_a", RDataA, 32'h22222222);
      check("byp_b", RDataB, 32'h22222222);
      check("nobyp_a", RDataA_nb, 32'h11111111);
      check("nobyp_b", RDataB_nb, 32'h11111111);
      tick();
      check("after_byp_a", RDataA, 32'h22222222);
      check("after_nobyp_b", RDataB_nb, 32'h22222222);
      RdEnA = 1'b0; RdEnB = 1'b0;

      // 5. Fill, then reset in RUN wipes everything
      for (int r = 1; r < 32; r++) write(5'(r), 32'(r));
      bad = 0;
      for (int r = 1; r < 32; r++) begin
         RdEnA = 1'b1; RAddrA = 5'(r); RdEnB = 1'b1; RAddrB = 5'(32 - r);
         tick();
         if (RDataA !== 32'(r) || RDataB_nb !== 32'(32 - r)) bad++;
      end
      check("fill_readback", 32'(bad), 32'd0);
      check("fill_x31_a", RDataA, 32'd31);
      Reset = 1'b1; RAddrA = 5'd31;
      We = 1'b1; WAddr = 5'd4; WData = 32'h55;
      tick();
      We = 1'b0;
      check("rst_run_ready", 32'(Ready), 32'd0);
      check("rst_run_rdata_a", RDataA, 32'h0);
      check("rst_run_rdata_b", RDataB, 32'h0);
      Reset = 1'b0; RdEnA = 1'b1; RAddrA = 5'd31;
      tick();
      check("clear_read_zero", RDataA, 32'h0);
      RdEnA = 1'b0; RdEnB = 1'b0;

      // 6. Write during CLEAR after x3 was already cleared -> ignored
      repeat (8) tick();
      write(5'd3, 32'h0000ABCD);
      wait_cnt = 0;
      while (!Ready && wait_cnt < 40) begin
         tick();
         wait_cnt++;
      end
      check("reclear_ready", 32'(Ready), 32'd1);
      check("reclear_latency", 32'(wait_cnt), 32'd22);
      RdEnA = 1'b1; RAddrA = 5'd3; RdEnB = 1'b1; RAddrB = 5'd3;
      tick();
      check("x3_ignored_a", RDataA, 32'h0);
      check("x3_ignored_b_nb", RDataB_nb, 32'h0);
      read_all_zero("post_reclear_zero");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_register_file
